// File: rtl/tanimoto_pkg.sv
// Shared definitions for the Tanimoto job controller: FSM encoding, table widths and the
// Q8.8 fraction width that the host driver also uses.
package tanimoto_pkg;

  localparam int FRAC_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_THR,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } job_state_t;

  // Threshold BRAM address width for a given fingerprint length.
  function automatic int cnt_width(input int vector_width);
    return $clog2(vector_width);
  endfunction

  // Threshold value width: one bit wider than the address so c itself is representable.
  function automatic int thr_width(input int vector_width);
    return cnt_width(vector_width) + 1;
  endfunction

endpackage

// File: rtl/tanimoto_thr_gen.sv
// Threshold table generator: after go, writes thr[c] = min((c*coef)>>8, max) for
// c = 0..VECTOR_WIDTH, one entry per cycle, then pulses last.
module tanimoto_thr_gen
  import tanimoto_pkg::*;
#(
  parameter int  VECTOR_WIDTH = 920,
  parameter int  COEF_WIDTH   = 16,
  localparam int CNT_WIDTH    = cnt_width(VECTOR_WIDTH),
  localparam int THR_WIDTH    = thr_width(VECTOR_WIDTH)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  go,
  input  logic [COEF_WIDTH-1:0] coef,
  output logic [CNT_WIDTH-1:0]  addr,
  output logic [THR_WIDTH-1:0]  data,
  output logic                  we,
  output logic                  last
);

  localparam int                    PROD_WIDTH = THR_WIDTH + COEF_WIDTH;
  localparam logic [CNT_WIDTH-1:0]  LAST_ADDR  = CNT_WIDTH'(VECTOR_WIDTH);
  localparam logic [PROD_WIDTH-1:0] THR_MAX    = PROD_WIDTH'((1 << THR_WIDTH) - 1);

  logic [COEF_WIDTH-1:0] coef_q;
  logic [THR_WIDTH-1:0]  c_next;
  logic [PROD_WIDTH-1:0] prod;
  logic [PROD_WIDTH-1:0] scaled;
  logic [THR_WIDTH-1:0]  data_next;

  // Full-width product so large coefficients saturate instead of wrapping.
  always_comb begin
    // NOTE: every signal is assigned on every pass, so no latch can be inferred.
    c_next    = {1'b0, addr} + THR_WIDTH'(1);
    prod      = PROD_WIDTH'(c_next) * PROD_WIDTH'(coef_q);
    scaled    = prod >> FRAC_WIDTH;
    data_next = (scaled > THR_MAX) ? THR_MAX[THR_WIDTH-1:0] : scaled[THR_WIDTH-1:0];
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      coef_q <= '0;
      addr   <= '0;
      data   <= '0;
      we     <= 1'b0;
      last   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so each register samples pre-edge values.
      last <= 1'b0;
      if (go) begin
        coef_q <= coef;
        addr   <= '0;
        data   <= '0;
        we     <= 1'b1;
      end else if (we) begin
        if (addr == LAST_ADDR) begin
          we   <= 1'b0;
          last <= 1'b1;
        end else begin
          addr <= addr + CNT_WIDTH'(1);
          data <= data_next;
        end
      end
    end
  end

endmodule

// File: rtl/tanimoto_job_ctrl.sv
// Per-job sequencer: loads the threshold table, gates the vector stream into the core with
// a generated tlast, then waits for the final ID pair before reporting done.
module tanimoto_job_ctrl
  import tanimoto_pkg::*;
#(
  parameter int  BUS_WIDTH    = 128,
  parameter int  VECTOR_WIDTH = 920,
  parameter int  COEF_WIDTH   = 16,
  parameter int  BEAT_WIDTH   = 32,
  localparam int CNT_WIDTH    = cnt_width(VECTOR_WIDTH),
  localparam int THR_WIDTH    = thr_width(VECTOR_WIDTH)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [BEAT_WIDTH-1:0] ref_beats,
  input  logic [BEAT_WIDTH-1:0] cmp_beats,
  input  logic [COEF_WIDTH-1:0] thr_coef,
  output logic                  busy,
  output logic                  done,
  output logic [BEAT_WIDTH-1:0] beat_cnt,
  output logic [BEAT_WIDTH-1:0] pair_cnt,
  output logic [CNT_WIDTH-1:0]  bram_addr,
  output logic [THR_WIDTH-1:0]  bram_wrdata,
  output logic                  bram_we,
  input  logic [BUS_WIDTH-1:0]  s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [BUS_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  id_tvalid,
  input  logic                  id_tready,
  input  logic                  id_tlast
);

  job_state_t            state;
  logic [BEAT_WIDTH-1:0] total;
  logic [BEAT_WIDTH-1:0] last_idx;
  logic                  streaming;
  logic                  data_beat;
  logic                  pair_hs;
  logic                  id_last_hs;
  logic                  thr_go;
  logic                  thr_last;

  assign thr_go = (state == ST_IDLE) && start;

  tanimoto_thr_gen #(
    .VECTOR_WIDTH (VECTOR_WIDTH),
    .COEF_WIDTH   (COEF_WIDTH)
  ) u_thr_gen (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .go     (thr_go),
    .coef   (thr_coef),
    .addr   (bram_addr),
    .data   (bram_wrdata),
    .we     (bram_we),
    .last   (thr_last)
  );

  // Zero-latency gate: upstream only sees ready while streaming, so nothing is dropped.
  always_comb begin
    streaming     = (state == ST_STREAM);
    last_idx      = total - BEAT_WIDTH'(1);
    m_axis_tdata  = s_axis_tdata;
    m_axis_tvalid = streaming && s_axis_tvalid;
    s_axis_tready = streaming && m_axis_tready;
    m_axis_tlast  = m_axis_tvalid && (beat_cnt == last_idx);
    data_beat     = m_axis_tvalid && m_axis_tready;
    pair_hs       = id_tvalid && id_tready;
    id_last_hs    = pair_hs && id_tlast;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      total    <= '0;
      beat_cnt <= '0;
      pair_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (data_beat) beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
      if (pair_hs && (state == ST_STREAM || state == ST_DRAIN))
        pair_cnt <= pair_cnt + BEAT_WIDTH'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            total    <= ref_beats + cmp_beats;
            beat_cnt <= '0;
            pair_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_LOAD_THR;
          end
        end
        ST_LOAD_THR: begin
          if (thr_last) begin
            if (total == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          // The final ID pair may land on the same edge as the last data beat.
          if (data_beat && m_axis_tlast) begin
            if (id_last_hs) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (id_last_hs) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tanimoto_job_ctrl.sv
// Randomized scoreboard bench for tanimoto_job_ctrl: stimulus pushes expectations,
// an independent negedge monitor pops and compares BRAM writes, stream beats and done.
module tb_tanimoto_job_ctrl;

  localparam int BUS_WIDTH    = 128;
  localparam int VECTOR_WIDTH = 920;
  localparam int COEF_WIDTH   = 16;
  localparam int BEAT_WIDTH   = 32;
  localparam int CNT_WIDTH    = 10;
  localparam int THR_WIDTH    = 11;
  localparam int THR_MAX      = 2047;

  typedef struct {
    int     beats;
    int     pairs;
    longint cyc;
  } done_exp_t;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst = 1'b1;
  logic                  start = 1'b0;
  logic [BEAT_WIDTH-1:0] ref_beats = '0;
  logic [BEAT_WIDTH-1:0] cmp_beats = '0;
  logic [COEF_WIDTH-1:0] thr_coef = '0;
  logic                  busy;
  logic                  done;
  logic [BEAT_WIDTH-1:0] beat_cnt;
  logic [BEAT_WIDTH-1:0] pair_cnt;
  logic [CNT_WIDTH-1:0]  bram_addr;
  logic [THR_WIDTH-1:0]  bram_wrdata;
  logic                  bram_we;
  logic [BUS_WIDTH-1:0]  s_axis_tdata = '0;
  logic                  s_axis_tvalid = 1'b0;
  logic                  s_axis_tready;
  logic [BUS_WIDTH-1:0]  m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready = 1'b0;
  logic                  id_tvalid = 1'b0;
  logic                  id_tready = 1'b0;
  logic                  id_tlast = 1'b0;

  int        n_cmp = 0;
  int        n_err = 0;
  longint    cyc = 0;
  bit        got_done = 1'b0;

  logic [CNT_WIDTH+THR_WIDTH-1:0] exp_bram[$];
  logic [BUS_WIDTH:0]             exp_beat[$];
  done_exp_t                      exp_done[$];

  tanimoto_job_ctrl #(
    .BUS_WIDTH    (BUS_WIDTH),
    .VECTOR_WIDTH (VECTOR_WIDTH),
    .COEF_WIDTH   (COEF_WIDTH),
    .BEAT_WIDTH   (BEAT_WIDTH)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .start         (start),
    .ref_beats     (ref_beats),
    .cmp_beats     (cmp_beats),
    .thr_coef      (thr_coef),
    .busy          (busy),
    .done          (done),
    .beat_cnt      (beat_cnt),
    .pair_cnt      (pair_cnt),
    .bram_addr     (bram_addr),
    .bram_wrdata   (bram_wrdata),
    .bram_we       (bram_we),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .id_tvalid     (id_tvalid),
    .id_tready     (id_tready),
    .id_tlast      (id_tlast)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference threshold: floor(c*coef/256), clipped to the table's value range.
  function automatic int model_thr(input int c, input int coef);
    longint v;
    v = (longint'(c) * longint'(coef)) / 256;
    return (v > THR_MAX) ? THR_MAX : int'(v);
  endfunction

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (bram_we) begin
        check("gate_closed_during_load", {s_axis_tready, m_axis_tvalid}, 0);
        if (exp_bram.size() == 0) check("bram_unexpected_write", 1, 0);
        else check("bram_write", {bram_addr, bram_wrdata}, exp_bram.pop_front());
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_beat.size() == 0) check("stream_unexpected_beat", 1, 0);
        else check("stream_beat", {m_axis_tlast, m_axis_tdata}, exp_beat.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          done_exp_t e;
          e = exp_done.pop_front();
          check("done_beat_cnt", beat_cnt, e.beats);
          check("done_pair_cnt", pair_cnt, e.pairs);
          check("done_cycle", cyc, e.cyc);
          check("busy_during_done", busy, 1);
        end
        got_done = 1'b1;
      end
    end
  end

  task automatic push_table(input int coef);
    for (int c = 0; c <= VECTOR_WIDTH; c++)
      exp_bram.push_back({CNT_WIDTH'(c), THR_WIDTH'(model_thr(c, coef))});
  endtask

  task automatic run_job(input int coef, input int nref, input int ncmp, input int vpct,
                         input int rpct, input bit coincide, input bit mid_start,
                         input bit done_start);
    int  total;
    int  idx;
    int  pairs;
    int  budget;
    bit  id_last_sent;
    bit  mid_done;
    bit  beat_s;
    bit  idhs_s;
    bit  idlast_s;
    logic [BUS_WIDTH-1:0] src[$];
    logic [BUS_WIDTH-1:0] w;

    total = nref + ncmp;
    push_table(coef);
    for (int k = 0; k < total; k++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      src.push_back(w);
      exp_beat.push_back({k == total - 1, w});
    end

    @(posedge ap_clk); #1;
    got_done  = 1'b0;
    start     = 1'b1;
    thr_coef  = COEF_WIDTH'(coef);
    ref_beats = nref;
    cmp_beats = ncmp;
    if (total == 0) exp_done.push_back('{0, 0, cyc + 923});
    @(posedge ap_clk); #1;
    start     = 1'b0;
    thr_coef  = COEF_WIDTH'($urandom);
    ref_beats = $urandom;
    cmp_beats = $urandom;

    idx = 0; pairs = 0; id_last_sent = 0; mid_done = 0;
    budget = 1200 + total * 40;
    for (int t = 0; t < budget && !got_done; t++) begin
      @(negedge ap_clk);
      beat_s   = s_axis_tvalid && s_axis_tready;
      idhs_s   = id_tvalid && id_tready;
      idlast_s = idhs_s && id_tlast;
      @(posedge ap_clk); #1;
      start = 1'b0;
      if (beat_s) idx++;
      if (idhs_s) pairs++;
      if (idlast_s) begin
        id_last_sent = 1;
        exp_done.push_back('{idx, pairs, cyc});
        if (done_start) start = 1'b1;
      end
      if (mid_start && !mid_done && idx > 0 && idx == total / 2) begin
        start    = 1'b1;
        mid_done = 1;
      end
      s_axis_tvalid = (idx < total) && ($urandom_range(99) < vpct);
      s_axis_tdata  = (idx < total) ? src[idx] : '0;
      m_axis_tready = ($urandom_range(99) < rpct);
      id_tvalid = 1'b0; id_tready = 1'b0; id_tlast = 1'b0;
      if (idx > 0 && !id_last_sent) begin
        if (idx == total) begin
          id_tvalid = 1'b1; id_tready = 1'b1; id_tlast = 1'b1;
        end else if (coincide && idx == total - 1) begin
          s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
          id_tvalid = 1'b1; id_tready = 1'b1; id_tlast = 1'b1;
        end else begin
          id_tvalid = ($urandom_range(3) == 0);
          id_tready = ($urandom_range(1) == 0);
        end
      end
    end

    start = 1'b0; s_axis_tvalid = 1'b0;
    id_tvalid = 1'b0; id_tready = 1'b0; id_tlast = 1'b0;
    if (!got_done) check("done_timeout", 0, 1);
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("busy_after_done", busy, 0);
    check("beat_cnt_hold", beat_cnt, total);
    check("bram_queue_drained", exp_bram.size(), 0);
    check("beat_queue_drained", exp_beat.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
    exp_bram.delete(); exp_beat.delete(); exp_done.delete();
  endtask

  initial begin
    #3;
    check("rst_ctrl_outputs", {busy, done, bram_we, s_axis_tready, m_axis_tvalid, m_axis_tlast}, 0);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_bram_wrdata", bram_wrdata, 0);
    check("rst_counters", {beat_cnt, pair_cnt}, 0);
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;

    run_job(1009, 58, 173, 100, 100, 0, 0, 0);
    run_job(16'hFFFF, 3, 5, 70, 70, 0, 0, 0);
    run_job($urandom_range(65535), 10, 30, 25, 50, 0, 0, 0);
    run_job($urandom_range(65535), 0, 0, 100, 100, 0, 0, 0);
    run_job($urandom_range(65535), 20, 20, 80, 80, 0, 1, 1);

    // Reset in the middle of the table load, then a fresh job must reload from address 0.
    push_table(777);
    @(posedge ap_clk); #1;
    start = 1'b1; thr_coef = 16'd777; ref_beats = 4; cmp_beats = 4;
    @(posedge ap_clk); #1;
    start = 1'b0;
    repeat (40) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    #1;
    check("midload_reset_we", bram_we, 0);
    check("midload_reset_busy", busy, 0);
    repeat (2) @(posedge ap_clk);
    exp_bram.delete(); exp_beat.delete(); exp_done.delete();
    #1 ap_rst = 1'b0;
    run_job(1009, 6, 7, 90, 90, 0, 0, 0);

    run_job(1009, 4, 9, 60, 60, 1, 0, 0);
    for (int j = 0; j < 3; j++) begin
      int nr;
      int nc;
      nr = $urandom_range(20);
      nc = $urandom_range(1, 20);
      run_job($urandom_range(65535), nr, nc, $urandom_range(20, 100), $urandom_range(20, 100),
              (nr + nc >= 2) && ($urandom_range(1) == 1), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
